adc_ltc2308_scan: RTL



---
 rtl/adc_ltc2308_scan.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_ltc2308_scan.sv
// adc_ltc2308_scan
//   Round-robin scan controller for the LTC2308 8-channel 12-bit SPI ADC.
//   While enabled it sweeps channels 0..NUM_CH-1 and runs the ADC's pipelined
//   protocol. The config word shifted in frame n selects the channel for
//   conversion n+1, so the first frame after IDLE is a discarded priming
//   frame. Tagged results are queued in an output FIFO with a valid/ready
//   handshake and a sticky overflow flag.
//
//   Frame: CONVST(2) -> WAIT(CONV_CYCLES) -> SHIFT(24*SCK_DIV) -> GAP(2).
//
//   Optional feature macro: ADC_SCAN_AVG_EN
//     defined   : each channel is converted 2^AVG_LOG2 times and one averaged
//                 entry (sum >> AVG_LOG2) is pushed.
//     undefined : one conversion per channel per pass; AVG_LOG2 is ignored.
//
// Ports
//   clk           sole clock
//   reset_n       asynchronous active-low reset
//   enable        level, high runs continuous scanning
//   uni           UNI bit of the config word (1 = unipolar)
//   ovf_clr       one-cycle pulse clearing overflow
//   sample_valid  FIFO head valid
//   sample_ready  consumer accepts head (pop on valid & ready)
//   sample_ch     channel of head entry
//   sample_data   conversion result of head entry
//   busy          FSM not in IDLE
//   overflow      sticky, set when a sample is dropped on a full FIFO
//   adc_convst    ADC CONVST
//   adc_sck       ADC SCK
//   adc_sdi       ADC SDI (config word, MSB first)
//   adc_sdo       ADC SDO (result, MSB first)

module adc_ltc2308_scan #(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned SCK_DIV     = 2,
    parameter int unsigned CONV_CYCLES = 80,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned AVG_LOG2    = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        uni,
    input  logic        ovf_clr,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [2:0]  sample_ch,
    output logic [11:0] sample_data,
    output logic        busy,
    output logic        overflow,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    localparam int unsigned REP_W = AVG_LOG2 + 1;
`ifdef ADC_SCAN_AVG_EN
    localparam int unsigned REPS  = 1 << AVG_LOG2;
`else
    localparam int unsigned REPS  = 1;
`endif
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVST,
        S_WAIT,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t             state;
    logic               en_q;
    logic [15:0]        cnt;        // phase counter; SCK half-period counter in SHIFT
    logic [3:0]         bit_idx;
    logic [11:0]        sdi_sr;
    logic [11:0]        sdo_sr;
    logic [2:0]         cfg_ch;     // channel encoded in this frame's SDI word
    logic [REP_W-1:0]   cfg_rep;    // repetition index of cfg_ch within its group
    logic [2:0]         res_ch;     // channel whose result this frame returns
    logic               res_last;   // this frame's result completes its group
    logic               priming;
    logic [2:0]         cfg_ch_next;
    logic [11:0]        cfg_word;
    logic               push_req;
    logic [11:0]        push_data;

    assign cfg_ch_next = (cfg_ch == 3'(NUM_CH - 1)) ? 3'd0 : cfg_ch + 3'd1;
    assign cfg_word    = {1'b1, cfg_ch[0], cfg_ch[2], cfg_ch[1], uni, 1'b0, 6'b000000};
    assign busy        = (state != S_IDLE);
    assign push_req    = (state == S_GAP) && (cnt == 16'd0) && !priming && res_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            en_q       <= 1'b0;
            cnt        <= '0;
            bit_idx    <= '0;
            sdi_sr     <= '0;
            sdo_sr     <= '0;
            cfg_ch     <= '0;
            cfg_rep    <= '0;
            res_ch     <= '0;
            res_last   <= 1'b0;
            priming    <= 1'b1;
            adc_convst <= 1'b0;
            adc_sck    <= 1'b0;
            adc_sdi    <= 1'b0;
        end else begin
            en_q <= enable;
            case (state)
                S_IDLE: begin
                    if (en_q) begin
                        state      <= S_CONVST;
                        adc_convst <= 1'b1;
                        cnt        <= '0;
                        priming    <= 1'b1;
                        cfg_ch     <= '0;
                        cfg_rep    <= '0;
                    end
                end
                S_CONVST: begin
                    if (cnt == 16'd1) begin
                        state      <= S_WAIT;
                        adc_convst <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_WAIT: begin
                    if (cnt == 16'(CONV_CYCLES - 1)) begin
                        state   <= S_SHIFT;
                        cnt     <= '0;
                        bit_idx <= '0;
                        adc_sdi <= cfg_word[11];
                        sdi_sr  <= {cfg_word[10:0], 1'b0};
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_SHIFT: begin
                    if (cnt == 16'(SCK_DIV - 1)) begin
                        cnt <= '0;
                        if (!adc_sck) begin
                            // rising SCK: capture SDO on the same clk edge
                            adc_sck <= 1'b1;
                            sdo_sr  <= {sdo_sr[10:0], adc_sdo};
                        end else if (bit_idx == 4'd11) begin
                            adc_sck <= 1'b0;
                            adc_sdi <= 1'b0;
                            state   <= S_GAP;
                        end else begin
                            // falling SCK: present next SDI bit for the low phase
                            adc_sck <= 1'b0;
                            adc_sdi <= sdi_sr[11];
                            sdi_sr  <= {sdi_sr[10:0], 1'b0};
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == 16'd0) begin
                        cnt <= 16'd1;
                    end else begin
                        cnt <= '0;
                        if (en_q) begin
                            state      <= S_CONVST;
                            adc_convst <= 1'b1;
                            priming    <= 1'b0;
                            res_ch     <= cfg_ch;
                            res_last   <= (cfg_rep == REP_W'(REPS - 1));
                            if (cfg_rep == REP_W'(REPS - 1)) begin
                                cfg_rep <= '0;
                                cfg_ch  <= cfg_ch_next;
                            end else begin
                                cfg_rep <= cfg_rep + REP_W'(1);
                            end
                        end else begin
                            state   <= S_IDLE;
                            priming <= 1'b1;
                            cfg_ch  <= '0;
                            cfg_rep <= '0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ADC_SCAN_AVG_EN
    localparam int unsigned ACC_W = 12 + AVG_LOG2;

    logic             res_first;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;

    assign acc_sum   = res_first ? ACC_W'(sdo_sr) : acc + ACC_W'(sdo_sr);
    assign push_data = acc_sum[AVG_LOG2 +: 12];

    // A re-enable restarts at cfg_rep 0, so a partial group's sum is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_first <= 1'b0;
            acc       <= '0;
        end else begin
            if (state == S_GAP && cnt == 16'd1 && en_q)
                res_first <= (cfg_rep == '0);
            if (state == S_GAP && cnt == 16'd0 && !priming)
                acc <= acc_sum;
        end
    end
`else
    assign push_data = sdo_sr;
`endif

    // Output FIFO
    logic [14:0]    mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic [PTR_W:0] fill;
    logic           full;
    logic           pop;
    logic           push_ok;
    logic           drop;

    assign fill         = wr_ptr - rd_ptr;
    assign full         = (fill == (PTR_W + 1)'(FIFO_DEPTH));
    assign sample_valid = (fill != '0);
    assign pop          = sample_valid && sample_ready;
    // a pop frees the slot in the same cycle, so push into a full FIFO is allowed then
    assign push_ok      = push_req && (!full || pop);
    assign drop         = push_req && full && !pop;
    assign {sample_ch, sample_data} = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[PTR_W-1:0]] <= {res_ch, push_data};
                wr_ptr                 <= wr_ptr + (PTR_W + 1)'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule
